// File: rtl/tx_chan_pkt_scheduler_pkg.sv
// Shared constants for the TX channel packet scheduler: FSM encodings and channel field sizing.
package tx_chan_pkt_scheduler_pkg;

  localparam int unsigned CHAN_W        = 5;
  localparam int unsigned PKT_WORDS_DEF = 128;

  typedef logic [CHAN_W-1:0] chan_t;

  // USB channel field value that addresses the control channel
  localparam chan_t CTRL_CHAN_ID = 5'h1f;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/tx_chan_pkt_scheduler_rr_pick.sv
// Rotating priority encoder: first requester strictly above last_grant, else lowest requester.
module tx_rr_pick
  import tx_chan_pkt_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  chan_t              last_grant,
  output chan_t              grant,
  output logic               any_req
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  chan_t lo_idx;
  chan_t hi_idx;
  logic  hi_hit;

  // Descending scan so the lowest qualifying index is the one left standing
  always_comb begin
    lo_idx  = '0;
    hi_idx  = '0;
    hi_hit  = 1'b0;
    any_req = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[IDX_W'(i)]) begin
        lo_idx  = CHAN_W'(i);
        any_req = 1'b1;
        if (CHAN_W'(i) > last_grant) begin
          hi_idx = CHAN_W'(i);
          hi_hit = 1'b1;
        end
      end
    end
    grant = hi_hit ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/tx_chan_pkt_scheduler.sv
// Grants one channel with a complete packet, streams its words out, pulses pkt_done, rotates.
// Optional macro TX_CTRL_PRIORITY_EN: control channel (index NUM_CHAN) always wins in IDLE.
module tx_chan_pkt_scheduler
  import tx_chan_pkt_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CHAN  = 2,
  parameter int unsigned PKT_WORDS = PKT_WORDS_DEF,
  parameter int unsigned CNT_W     = 7
) (
  input  logic              txclk,
  input  logic              reset,
  input  logic [NUM_CHAN:0] have_pkt,
  input  logic              rd_ready,
  output logic [NUM_CHAN:0] rd_en,
  output logic              sop,
  output logic              eop,
  output logic [NUM_CHAN:0] pkt_done,
  output logic              grant_valid,
  output logic [CHAN_W-1:0] grant_chan,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned      NUM_REQ   = NUM_CHAN + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PKT_WORDS - 1);
  localparam chan_t            CTRL_IDX  = CHAN_W'(NUM_CHAN);

  logic [1:0]        state, state_nxt;
  chan_t             last_grant, last_grant_nxt;
  chan_t             grant_chan_nxt;
  logic              grant_valid_nxt;
  logic [CNT_W-1:0]  word_cnt_nxt;
  logic [NUM_CHAN:0] pkt_done_nxt;
  logic [NUM_CHAN:0] grant_mask;
  chan_t             rr_grant, pick_chan;
  logic              rr_any;

  tx_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req        (have_pkt),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .any_req    (rr_any)
  );

  always_comb begin
    pick_chan = rr_grant;
`ifdef TX_CTRL_PRIORITY_EN
    if (have_pkt[NUM_CHAN]) pick_chan = CTRL_IDX;
`endif
  end

  assign grant_mask = {{NUM_CHAN{1'b0}}, 1'b1} << grant_chan;

  always_comb begin
    state_nxt       = state;
    grant_valid_nxt = grant_valid;
    grant_chan_nxt  = grant_chan;
    word_cnt_nxt    = word_cnt;
    last_grant_nxt  = last_grant;
    pkt_done_nxt    = '0;
    rd_en           = '0;
    sop             = 1'b0;
    eop             = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rr_any) begin
          grant_chan_nxt  = pick_chan;
          grant_valid_nxt = 1'b1;
          word_cnt_nxt    = '0;
          state_nxt       = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_ready) begin
          rd_en = grant_mask;
          sop   = (word_cnt == '0);
          eop   = (word_cnt == LAST_WORD);
          // Counter holds on the last word so it never wraps
          if (eop) begin
            pkt_done_nxt = grant_mask;
            state_nxt    = ST_DONE;
          end else begin
            word_cnt_nxt = word_cnt + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        grant_valid_nxt = 1'b0;
        state_nxt       = ST_IDLE;
`ifdef TX_CTRL_PRIORITY_EN
        if (grant_chan != CTRL_IDX) last_grant_nxt = grant_chan;
`else
        last_grant_nxt = grant_chan;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant_valid <= 1'b0;
      grant_chan  <= '0;
      word_cnt    <= '0;
      pkt_done    <= '0;
      last_grant  <= CTRL_IDX;
    end else begin
      state       <= state_nxt;
      grant_valid <= grant_valid_nxt;
      grant_chan  <= grant_chan_nxt;
      word_cnt    <= word_cnt_nxt;
      pkt_done    <= pkt_done_nxt;
      last_grant  <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_tx_chan_pkt_scheduler.sv
// Scoreboard bench for tx_chan_pkt_scheduler (NUM_CHAN=2, 128-word packets).
module tb_tx_chan_pkt_scheduler;

  logic       txclk = 1'b0;
  logic       reset;
  logic [2:0] have_pkt;
  logic       rd_ready;
  logic [2:0] rd_en;
  logic       sop, eop;
  logic [2:0] pkt_done;
  logic       grant_valid;
  logic [4:0] grant_chan;
  logic [6:0] word_cnt;

  typedef struct {
    logic [2:0] rd_en;
    logic       sop;
    logic       eop;
    logic [6:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  tx_chan_pkt_scheduler dut (
    .txclk       (txclk),
    .reset       (reset),
    .have_pkt    (have_pkt),
    .rd_ready    (rd_ready),
    .rd_en       (rd_en),
    .sop         (sop),
    .eop         (eop),
    .pkt_done    (pkt_done),
    .grant_valid (grant_valid),
    .grant_chan  (grant_chan),
    .word_cnt    (word_cnt)
  );

  always #5 txclk = ~txclk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic void push_pkt(input int ch, input int nwords);
    for (int w = 0; w < nwords; w++)
      exp_q.push_back('{3'(1 << ch), (w == 0), (w == 127), 7'(w)});
  endfunction

  task automatic do_reset();
    reset = 1'b1; have_pkt = '0; rd_ready = 1'b0;
    repeat (2) @(negedge txclk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; have_pkt = '0; rd_ready = 1'b0;
    repeat (3) @(negedge txclk);
    cmp_cnt++;
    if ({grant_valid, grant_chan, word_cnt, pkt_done, rd_en, sop, eop} !== 21'd0) begin
      err_cnt++;
      $display("FAIL reset_state gv=%b ch=%0d cnt=%0d done=%b rd_en=%b want all 0",
               grant_valid, grant_chan, word_cnt, pkt_done, rd_en);
    end
    reset = 1'b0; rd_ready = 1'b1;
    repeat (3) begin
      @(negedge txclk);
      cmp_cnt++;
      if ({grant_valid, rd_en} !== 4'd0) begin
        err_cnt++;
        $display("FAIL idle_no_req gv=%b rd_en=%b want 0/000", grant_valid, rd_en);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    int first = -1, eop_at = -1;
    do_reset();
    push_pkt(0, 128);
    have_pkt = 3'b001; rd_ready = 1'b1;
    for (int c = 1; c <= 200 && eop_at < 0; c++) begin
      @(negedge txclk);
      have_pkt = 3'b000;
      if (rd_en !== 3'b000) begin
        if (first < 0) first = c;
        if (eop === 1'b1) eop_at = c;
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++; $display("FAIL single_extra_read rd_en=%b", rd_en);
        end else begin
          e = exp_q.pop_front();
          if ({rd_en, sop, eop, word_cnt} !== {e.rd_en, e.sop, e.eop, e.cnt}) begin
            err_cnt++;
            $display("FAIL single_word got rd_en=%b sop=%b eop=%b cnt=%0d want rd_en=%b sop=%b eop=%b cnt=%0d",
                     rd_en, sop, eop, word_cnt, e.rd_en, e.sop, e.eop, e.cnt);
          end
        end
      end
    end
    cmp_cnt++;
    if (first != 1 || eop_at != 128) begin
      err_cnt++; $display("FAIL single_timing first=%0d eop=%0d want 1/128", first, eop_at);
    end
    @(negedge txclk);
    cmp_cnt++;
    if ({pkt_done, rd_en} !== 6'b001_000) begin
      err_cnt++; $display("FAIL single_done pkt_done=%b rd_en=%b want 001/000", pkt_done, rd_en);
    end
    @(negedge txclk);
    cmp_cnt++;
    if ({pkt_done, grant_valid, rd_en} !== 7'd0 || exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL single_after pkt_done=%b gv=%b rd_en=%b left=%0d want 000/0/000/0",
               pkt_done, grant_valid, rd_en, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n_eop = 0, last_eop = -1;
    do_reset();
    push_pkt(0, 128); push_pkt(1, 128); push_pkt(2, 128); push_pkt(0, 128);
    have_pkt = 3'b111; rd_ready = 1'b1;
    for (int c = 1; c <= 700 && n_eop < 4; c++) begin
      @(negedge txclk);
      if (rd_en !== 3'b000) begin
        if (sop === 1'b1 && last_eop >= 0) begin
          cmp_cnt++;
          if (c - last_eop - 1 != 2) begin
            err_cnt++; $display("FAIL b2b_gap got=%0d want=2", c - last_eop - 1);
          end
        end
        if (eop === 1'b1) begin
          last_eop = c; n_eop++;
          if (n_eop == 4) have_pkt = 3'b000;
        end
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++; $display("FAIL b2b_extra_read rd_en=%b", rd_en);
        end else begin
          e = exp_q.pop_front();
          if ({rd_en, sop, eop, word_cnt} !== {e.rd_en, e.sop, e.eop, e.cnt}) begin
            err_cnt++;
            $display("FAIL b2b_word got rd_en=%b sop=%b eop=%b cnt=%0d want rd_en=%b sop=%b eop=%b cnt=%0d",
                     rd_en, sop, eop, word_cnt, e.rd_en, e.sop, e.eop, e.cnt);
          end
        end
      end
    end
    repeat (3) @(negedge txclk);
    cmp_cnt++;
    if (n_eop != 4 || exp_q.size() != 0 || grant_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_end eops=%0d left=%0d gv=%b want 4/0/0", n_eop, exp_q.size(), grant_valid);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int first = -1, eop_at = -1;
    do_reset();
    push_pkt(1, 128);
    have_pkt = 3'b010; rd_ready = 1'b1;
    for (int c = 1; c <= 400 && eop_at < 0; c++) begin
      @(negedge txclk);
      have_pkt = 3'b000;
      if (rd_en !== 3'b000) begin
        if (first < 0) first = c;
        if (eop === 1'b1) eop_at = c;
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++; $display("FAIL stall_extra_read rd_en=%b", rd_en);
        end else begin
          e = exp_q.pop_front();
          if ({rd_en, sop, eop, word_cnt} !== {e.rd_en, e.sop, e.eop, e.cnt}) begin
            err_cnt++;
            $display("FAIL stall_word got rd_en=%b sop=%b eop=%b cnt=%0d want rd_en=%b sop=%b eop=%b cnt=%0d",
                     rd_en, sop, eop, word_cnt, e.rd_en, e.sop, e.eop, e.cnt);
          end
        end
      end
      rd_ready = ~rd_ready;
    end
    rd_ready = 1'b1;
    cmp_cnt++;
    if (first != 1 || eop_at - first + 1 != 255) begin
      err_cnt++; $display("FAIL stall_span first=%0d span=%0d want 1/255", first, eop_at - first + 1);
    end
    repeat (2) @(negedge txclk);
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int hit = 0, eop_at = -1;
    do_reset();
    for (int w = 0; w <= 60; w++) exp_q.push_back('{3'b001, (w == 0), 1'b0, 7'(w)});
    have_pkt = 3'b001; rd_ready = 1'b1;
    for (int c = 1; c <= 100 && hit == 0; c++) begin
      @(negedge txclk);
      have_pkt = 3'b000;
      if (rd_en !== 3'b000) begin
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++; $display("FAIL rst_extra_read rd_en=%b", rd_en);
        end else begin
          e = exp_q.pop_front();
          if ({rd_en, sop, eop, word_cnt} !== {e.rd_en, e.sop, e.eop, e.cnt}) begin
            err_cnt++;
            $display("FAIL rst_word got rd_en=%b sop=%b eop=%b cnt=%0d want rd_en=%b sop=%b eop=%b cnt=%0d",
                     rd_en, sop, eop, word_cnt, e.rd_en, e.sop, e.eop, e.cnt);
          end
        end
        if (word_cnt == 7'd60) hit = 1;
      end
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge txclk);
      cmp_cnt++;
      if ({grant_valid, grant_chan, word_cnt, pkt_done, rd_en, sop, eop} !== 21'd0 || hit == 0) begin
        err_cnt++;
        $display("FAIL mid_reset gv=%b ch=%0d cnt=%0d done=%b rd_en=%b hit=%0d want all 0, hit 1",
                 grant_valid, grant_chan, word_cnt, pkt_done, rd_en, hit);
      end
    end
    reset = 1'b0; have_pkt = 3'b110;
    exp_q.delete();
    push_pkt(1, 128);
    for (int c = 1; c <= 200 && eop_at < 0; c++) begin
      @(negedge txclk);
      if (c == 1) begin
        have_pkt = 3'b000;
        cmp_cnt++;
        if ({grant_valid, grant_chan} !== 6'b1_00001) begin
          err_cnt++; $display("FAIL post_reset_grant gv=%b ch=%0d want 1/1", grant_valid, grant_chan);
        end
      end
      if (rd_en !== 3'b000) begin
        if (eop === 1'b1) eop_at = c;
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++; $display("FAIL post_rst_extra_read rd_en=%b", rd_en);
        end else begin
          e = exp_q.pop_front();
          if ({rd_en, sop, eop, word_cnt} !== {e.rd_en, e.sop, e.eop, e.cnt}) begin
            err_cnt++;
            $display("FAIL post_rst_word got rd_en=%b sop=%b eop=%b cnt=%0d want rd_en=%b sop=%b eop=%b cnt=%0d",
                     rd_en, sop, eop, word_cnt, e.rd_en, e.sop, e.eop, e.cnt);
          end
        end
      end
    end
    repeat (2) @(negedge txclk);
  endtask

  // Buffer model: a channel's have_pkt drops when its pkt_done pulse is seen
  task automatic test_ctrl_order();
    exp_t e;
    int n_eop = 0;
    do_reset();
    push_pkt(0, 128);
`ifdef TX_CTRL_PRIORITY_EN
    push_pkt(2, 128); push_pkt(1, 128);
`else
    push_pkt(1, 128); push_pkt(2, 128);
`endif
    have_pkt = 3'b001; rd_ready = 1'b1;
    for (int c = 1; c <= 600 && n_eop < 3; c++) begin
      @(negedge txclk);
      if (c == 1) have_pkt = 3'b111;
      have_pkt = have_pkt & ~pkt_done;
      if (rd_en !== 3'b000) begin
        if (eop === 1'b1) n_eop++;
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++; $display("FAIL order_extra_read rd_en=%b", rd_en);
        end else begin
          e = exp_q.pop_front();
          if ({rd_en, sop, eop, word_cnt} !== {e.rd_en, e.sop, e.eop, e.cnt}) begin
            err_cnt++;
            $display("FAIL order_word got rd_en=%b sop=%b eop=%b cnt=%0d want rd_en=%b sop=%b eop=%b cnt=%0d",
                     rd_en, sop, eop, word_cnt, e.rd_en, e.sop, e.eop, e.cnt);
          end
        end
      end
    end
    repeat (3) begin
      @(negedge txclk);
      have_pkt = have_pkt & ~pkt_done;
    end
    cmp_cnt++;
    if (n_eop != 3 || exp_q.size() != 0 || grant_valid !== 1'b0 || have_pkt !== 3'b000) begin
      err_cnt++;
      $display("FAIL order_end eops=%0d left=%0d gv=%b have=%b want 3/0/0/000",
               n_eop, exp_q.size(), grant_valid, have_pkt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_ctrl_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
